// File: rtl/bats_parser_ip.sv
// bats_parser_ip: decodes BATS/CBOE PITCH sequenced units from 64-bit payload words into order-book commands.
// Optional debug mirror of accepted input words is built when BATS_DEBUG_EN is defined.
`timescale 1ns/1ps
module bats_parser_ip #(
    parameter int MSG_BUF_BYTES = 40
) (
    input  logic        Clk40,
    input  logic        reset,
    input  logic        enable_in,
    output logic        enable_out,
    input  logic        enable_clr,
    input  logic        ctrlind_00_Ready_For_Debug,
    output logic        ctrlind_01_Debug_Valid,
    output logic [63:0] ctrlind_02_Debug_Element,
    input  logic        ctrlind_03_Ready_for_OrderBook_Command,
    output logic        ctrlind_04_OrderBook_Command_Valid,
    output logic [63:0] ctrlind_05_Nanoseconds_U64,
    output logic [63:0] ctrlind_06_Seconds_U64,
    output logic [31:0] ctrlind_07_Remaining_Quantity_U32,
    output logic [31:0] ctrlind_08_Canceled_Quantity_U32,
    output logic [31:0] ctrlind_09_Executed_Quantity_U32,
    output logic [63:0] ctrlind_10_Price_U64,
    output logic [63:0] ctrlind_11_Symbol_U64,
    output logic [31:0] ctrlind_12_Quantity_U32,
    output logic [63:0] ctrlind_13_Order_Id_U64,
    output logic [7:0]  ctrlind_14_Side_U8,
    output logic [7:0]  ctrlind_15_OrderBook_Command_Type,
    input  logic        ctrlind_16_reset,
    input  logic [63:0] ctrlind_17_Bytes,
    input  logic [7:0]  ctrlind_18_Byte_Enables,
    input  logic        ctrlind_19_data_valid,
    output logic        ctrlind_20_Ready_for_Udp_Input,
    output logic [63:0] ctrlind_21_Bytes_echo,
    output logic [7:0]  ctrlind_22_Bytes_Valid
);

    localparam int BUF_W = MSG_BUF_BYTES * 8;

    typedef enum logic [1:0] {
        ST_HDR  = 2'd0,
        ST_MSG  = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    typedef struct packed {
        logic [7:0]  typ;
        logic [31:0] ns;
        logic [31:0] sec;
        logic [31:0] cxl;
        logic [31:0] exe;
        logic [63:0] price;
        logic [47:0] sym;
        logic [31:0] qty;
        logic [63:0] oid;
        logic [7:0]  side;
    } cmd_t;

    function automatic logic [7:0] buf_byte(input logic [BUF_W-1:0] b, input int idx);
        if (idx < MSG_BUF_BYTES) begin
            return b[idx*8 +: 8];
        end else begin
            return 8'h00;
        end
    endfunction

    // Little-endian field of n bytes starting at message offset off.
    function automatic logic [63:0] le_field(input logic [BUF_W-1:0] b, input int off, input int n);
        logic [63:0] v;
        v = 64'h0;
        for (int k = 0; k < 8; k++) begin
            if (k < n) begin
                v[k*8 +: 8] = buf_byte(b, off + k);
            end else begin
                v[k*8 +: 8] = 8'h00;
            end
        end
        return v;
    endfunction

    // Symbol keeps wire order: first character lands in the top byte.
    function automatic logic [47:0] sym_field(input logic [BUF_W-1:0] b, input int off);
        logic [47:0] s;
        s = 48'h0;
        for (int k = 0; k < 6; k++) begin
            s[47 - k*8 -: 8] = buf_byte(b, off + k);
        end
        return s;
    endfunction

    state_t            state_q, state_d;
    logic [2:0]        hdr_cnt_q, hdr_cnt_d;
    logic [15:0]       hdr_len_q, hdr_len_d;
    logic [15:0]       rem_q, rem_d;
    logic [7:0]        msg_idx_q, msg_idx_d;
    logic [7:0]        msg_len_q, msg_len_d;
    logic [BUF_W-1:0]  buf_q, buf_d;
    logic [31:0]       seconds_q, seconds_d;
    logic [63:0]       word_q, word_d;
    logic [7:0]        lanes_q, lanes_d;
    logic [63:0]       echo_q, echo_d;
    logic [7:0]        echo_be_q, echo_be_d;
    logic              enable_out_q;
    logic              cmd_valid_q, cmd_valid_d;
    cmd_t              cmd_q, cmd_d;
    cmd_t              dec_s;
    logic              dec_hit_s;

    logic              clear_s;
    logic              ready_s;
    logic              accept_s;
    logic              byte_go_s;
    logic              msg_done_s;
    logic              dbg_block_s;
    logic [2:0]        sel_s;
    logic [7:0]        cur_byte_s;

    assign clear_s   = reset | ctrlind_16_reset | enable_clr;
    assign ready_s   = enable_in & (lanes_q == 8'h00) & ~cmd_valid_q & ~dbg_block_s;
    assign accept_s  = ctrlind_19_data_valid & ready_s;
    assign byte_go_s = enable_in & (lanes_q != 8'h00)
                       & (~cmd_valid_q | ctrlind_03_Ready_for_OrderBook_Command);

    // Pick the highest still-enabled lane as the next wire byte.
    always_comb begin
        sel_s = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (lanes_q[i]) begin
                sel_s = 3'(i);
            end else begin
                sel_s = sel_s;
            end
        end
        cur_byte_s = word_q[{sel_s, 3'b000} +: 8];
    end

    // Word capture and per-byte lane retirement.
    always_comb begin
        word_d    = word_q;
        lanes_d   = lanes_q;
        echo_d    = echo_q;
        echo_be_d = echo_be_q;
        if (accept_s) begin
            word_d    = ctrlind_17_Bytes;
            lanes_d   = ctrlind_18_Byte_Enables;
            echo_d    = ctrlind_17_Bytes;
            echo_be_d = ctrlind_18_Byte_Enables;
        end else if (byte_go_s) begin
            lanes_d[sel_s] = 1'b0;
        end else begin
            lanes_d = lanes_q;
        end
    end

    // Packet walker: header, message assembly and discard of malformed remainder.
    always_comb begin
        state_d    = state_q;
        hdr_cnt_d  = hdr_cnt_q;
        hdr_len_d  = hdr_len_q;
        rem_d      = rem_q;
        msg_idx_d  = msg_idx_q;
        msg_len_d  = msg_len_q;
        buf_d      = buf_q;
        msg_done_s = 1'b0;
        if (byte_go_s) begin
            case (state_q)
                ST_HDR: begin
                    hdr_cnt_d = hdr_cnt_q + 3'd1;
                    if (hdr_cnt_q == 3'd0) begin
                        hdr_len_d[7:0] = cur_byte_s;
                    end else if (hdr_cnt_q == 3'd1) begin
                        hdr_len_d[15:8] = cur_byte_s;
                    end else if (hdr_cnt_q == 3'd7) begin
                        if (hdr_len_q > 16'd8) begin
                            rem_d     = hdr_len_q - 16'd8;
                            msg_idx_d = 8'd0;
                            state_d   = ST_MSG;
                        end else begin
                            state_d = ST_HDR;
                        end
                    end else begin
                        hdr_len_d = hdr_len_q;
                    end
                end
                ST_MSG: begin
                    rem_d = rem_q - 16'd1;
                    if (msg_idx_q == 8'd0) begin
                        if ((cur_byte_s < 8'd2) || ({8'd0, cur_byte_s} > rem_q)) begin
                            state_d = (rem_q == 16'd1) ? ST_HDR : ST_DROP;
                        end else begin
                            msg_len_d      = cur_byte_s;
                            buf_d          = '0;
                            buf_d[7:0]     = cur_byte_s;
                            msg_idx_d      = 8'd1;
                        end
                    end else begin
                        for (int i = 0; i < MSG_BUF_BYTES; i++) begin
                            if (msg_idx_q == 8'(i)) begin
                                buf_d[i*8 +: 8] = cur_byte_s;
                            end else begin
                                buf_d[i*8 +: 8] = buf_q[i*8 +: 8];
                            end
                        end
                        if (msg_idx_q == msg_len_q - 8'd1) begin
                            msg_done_s = 1'b1;
                            msg_idx_d  = 8'd0;
                            state_d    = (rem_q == 16'd1) ? ST_HDR : ST_MSG;
                        end else begin
                            msg_idx_d = msg_idx_q + 8'd1;
                        end
                    end
                end
                ST_DROP: begin
                    rem_d   = rem_q - 16'd1;
                    state_d = (rem_q == 16'd1) ? ST_HDR : ST_DROP;
                end
                default: begin
                    state_d = ST_HDR;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Message decode from the assembled buffer including the byte arriving this cycle.
    always_comb begin
        dec_s     = '0;
        dec_hit_s = 1'b1;
        dec_s.sec = seconds_q;
        dec_s.ns  = 32'(le_field(buf_d, 2, 4));
        dec_s.oid = le_field(buf_d, 6, 8);
        case (buf_byte(buf_d, 1))
            8'h20: begin
                dec_s     = '0;
                dec_s.typ = 8'h01;
                dec_s.sec = 32'(le_field(buf_d, 2, 4));
            end
            8'h21: begin
                dec_s.typ   = 8'h02;
                dec_s.side  = buf_byte(buf_d, 14);
                dec_s.qty   = 32'(le_field(buf_d, 15, 4));
                dec_s.sym   = sym_field(buf_d, 19);
                dec_s.price = le_field(buf_d, 25, 8);
            end
            8'h22: begin
                dec_s.typ   = 8'h02;
                dec_s.side  = buf_byte(buf_d, 14);
                dec_s.qty   = 32'(le_field(buf_d, 15, 2));
                dec_s.sym   = sym_field(buf_d, 17);
                dec_s.price = le_field(buf_d, 23, 2) * 64'd100;
            end
            8'h23: begin
                dec_s.typ = 8'h03;
                dec_s.exe = 32'(le_field(buf_d, 14, 4));
            end
            8'h25: begin
                dec_s.typ = 8'h04;
                dec_s.cxl = 32'(le_field(buf_d, 14, 4));
            end
            8'h26: begin
                dec_s.typ = 8'h04;
                dec_s.cxl = 32'(le_field(buf_d, 14, 2));
            end
            8'h29: begin
                dec_s.typ = 8'h05;
            end
            default: begin
                dec_s     = '0;
                dec_hit_s = 1'b0;
            end
        endcase
    end

    // Command register and valid/ready handshake; Time messages also refresh latched seconds.
    always_comb begin
        cmd_valid_d = cmd_valid_q;
        cmd_d       = cmd_q;
        seconds_d   = seconds_q;
        if (cmd_valid_q && ctrlind_03_Ready_for_OrderBook_Command) begin
            cmd_valid_d = 1'b0;
        end else begin
            cmd_valid_d = cmd_valid_q;
        end
        if (msg_done_s && dec_hit_s) begin
            cmd_valid_d = 1'b1;
            cmd_d       = dec_s;
            if (dec_s.typ == 8'h01) begin
                seconds_d = dec_s.sec;
            end else begin
                seconds_d = seconds_q;
            end
        end else begin
            cmd_d = cmd_q;
        end
    end

    // State registers; everything holds while enable_in is low.
    always_ff @(posedge Clk40) begin
        if (clear_s) begin
            state_q     <= ST_HDR;
            hdr_cnt_q   <= 3'd0;
            hdr_len_q   <= 16'd0;
            rem_q       <= 16'd0;
            msg_idx_q   <= 8'd0;
            msg_len_q   <= 8'd0;
            buf_q       <= '0;
            seconds_q   <= 32'd0;
            word_q      <= 64'd0;
            lanes_q     <= 8'd0;
            echo_q      <= 64'd0;
            echo_be_q   <= 8'd0;
            cmd_valid_q <= 1'b0;
            cmd_q       <= '0;
        end else if (enable_in) begin
            state_q     <= state_d;
            hdr_cnt_q   <= hdr_cnt_d;
            hdr_len_q   <= hdr_len_d;
            rem_q       <= rem_d;
            msg_idx_q   <= msg_idx_d;
            msg_len_q   <= msg_len_d;
            buf_q       <= buf_d;
            seconds_q   <= seconds_d;
            word_q      <= word_d;
            lanes_q     <= lanes_d;
            echo_q      <= echo_d;
            echo_be_q   <= echo_be_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_q       <= cmd_d;
        end
    end

    // Inverted enable mirror runs regardless of enable_in.
    always_ff @(posedge Clk40) begin
        if (clear_s) begin
            enable_out_q <= 1'b0;
        end else begin
            enable_out_q <= ~enable_in;
        end
    end

`ifdef BATS_DEBUG_EN
    logic        dbg_valid_q, dbg_valid_d;
    logic [63:0] dbg_elem_q, dbg_elem_d;

    // Debug mirror holds each accepted word until the debug sink takes it.
    always_comb begin
        dbg_valid_d = dbg_valid_q;
        dbg_elem_d  = dbg_elem_q;
        if (accept_s) begin
            dbg_valid_d = 1'b1;
            dbg_elem_d  = ctrlind_17_Bytes;
        end else if (dbg_valid_q && ctrlind_00_Ready_For_Debug) begin
            dbg_valid_d = 1'b0;
        end else begin
            dbg_valid_d = dbg_valid_q;
        end
    end

    // Debug registers.
    always_ff @(posedge Clk40) begin
        if (clear_s) begin
            dbg_valid_q <= 1'b0;
            dbg_elem_q  <= 64'd0;
        end else if (enable_in) begin
            dbg_valid_q <= dbg_valid_d;
            dbg_elem_q  <= dbg_elem_d;
        end
    end

    assign dbg_block_s              = dbg_valid_q;
    assign ctrlind_01_Debug_Valid   = dbg_valid_q;
    assign ctrlind_02_Debug_Element = dbg_elem_q;
`else
    logic dbg_unused_s;
    assign dbg_unused_s             = ctrlind_00_Ready_For_Debug;
    assign dbg_block_s              = 1'b0;
    assign ctrlind_01_Debug_Valid   = 1'b0;
    assign ctrlind_02_Debug_Element = 64'd0;
`endif

    assign enable_out                         = enable_out_q;
    assign ctrlind_04_OrderBook_Command_Valid = cmd_valid_q;
    assign ctrlind_05_Nanoseconds_U64         = {32'd0, cmd_q.ns};
    assign ctrlind_06_Seconds_U64             = {32'd0, cmd_q.sec};
    assign ctrlind_07_Remaining_Quantity_U32  = 32'd0;
    assign ctrlind_08_Canceled_Quantity_U32   = cmd_q.cxl;
    assign ctrlind_09_Executed_Quantity_U32   = cmd_q.exe;
    assign ctrlind_10_Price_U64               = cmd_q.price;
    assign ctrlind_11_Symbol_U64              = {cmd_q.sym, 16'h0000};
    assign ctrlind_12_Quantity_U32            = cmd_q.qty;
    assign ctrlind_13_Order_Id_U64            = cmd_q.oid;
    assign ctrlind_14_Side_U8                 = cmd_q.side;
    assign ctrlind_15_OrderBook_Command_Type  = cmd_q.typ;
    assign ctrlind_20_Ready_for_Udp_Input     = ready_s;
    assign ctrlind_21_Bytes_echo              = echo_q;
    assign ctrlind_22_Bytes_Valid             = echo_be_q;

endmodule

// File: tb/tb_bats_parser_ip.sv
// Randomized bench for bats_parser_ip: packets are built from message descriptions and the
// expected commands are derived directly from those descriptions, then compared at the command port.
`timescale 1ns/1ps
module tb_bats_parser_ip;

    logic        clk = 1'b0;
    logic        reset, enable_in, enable_clr, soft_rst;
    logic        dbg_rdy, cmd_rdy, data_valid;
    logic [63:0] bytes_in;
    logic [7:0]  be_in;
    logic        enable_out, dbg_valid, cmd_valid, udp_rdy;
    logic [63:0] dbg_elem, ns_o, sec_o, price_o, sym_o, oid_o, echo_o;
    logic [31:0] rem_o, cxl_o, exe_o, qty_o;
    logic [7:0]  side_o, type_o, echo_be_o;

    always #5 clk = ~clk;

    bats_parser_ip #(.MSG_BUF_BYTES(40)) dut (
        .Clk40(clk), .reset(reset), .enable_in(enable_in), .enable_out(enable_out),
        .enable_clr(enable_clr),
        .ctrlind_00_Ready_For_Debug(dbg_rdy), .ctrlind_01_Debug_Valid(dbg_valid),
        .ctrlind_02_Debug_Element(dbg_elem),
        .ctrlind_03_Ready_for_OrderBook_Command(cmd_rdy),
        .ctrlind_04_OrderBook_Command_Valid(cmd_valid),
        .ctrlind_05_Nanoseconds_U64(ns_o), .ctrlind_06_Seconds_U64(sec_o),
        .ctrlind_07_Remaining_Quantity_U32(rem_o), .ctrlind_08_Canceled_Quantity_U32(cxl_o),
        .ctrlind_09_Executed_Quantity_U32(exe_o), .ctrlind_10_Price_U64(price_o),
        .ctrlind_11_Symbol_U64(sym_o), .ctrlind_12_Quantity_U32(qty_o),
        .ctrlind_13_Order_Id_U64(oid_o), .ctrlind_14_Side_U8(side_o),
        .ctrlind_15_OrderBook_Command_Type(type_o), .ctrlind_16_reset(soft_rst),
        .ctrlind_17_Bytes(bytes_in), .ctrlind_18_Byte_Enables(be_in),
        .ctrlind_19_data_valid(data_valid), .ctrlind_20_Ready_for_Udp_Input(udp_rdy),
        .ctrlind_21_Bytes_echo(echo_o), .ctrlind_22_Bytes_Valid(echo_be_o)
    );

    typedef struct {
        logic [7:0]  typ;
        logic [63:0] ns, sec, price, sym, oid;
        logic [31:0] cxl, exe, qty;
        logic [7:0]  side;
    } cmd_t;

    cmd_t        exp_q[$];
    logic [7:0]  body_q[$];
    logic [7:0]  pkt_q[$];
    logic [31:0] model_sec;
    bit          dropping;
    int          n_msgs, seq_no;
    int          n_checks = 0, n_pass = 0, n_xfer = 0;
    int          rdy_mode = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic cmd_t zero_cmd(input logic [7:0] typ);
        cmd_t c;
        c.typ = typ; c.ns = 64'd0; c.sec = {32'd0, model_sec}; c.price = 64'd0; c.sym = 64'd0;
        c.oid = 64'd0; c.cxl = 32'd0; c.exe = 32'd0; c.qty = 32'd0; c.side = 8'd0;
        return c;
    endfunction

    function automatic void put_le(input logic [63:0] v, input int n);
        for (int k = 0; k < n; k++) body_q.push_back(v[k*8 +: 8]);
    endfunction

    function automatic void push_exp(input cmd_t c);
        if (!dropping) exp_q.push_back(c);
    endfunction

    function automatic void add_time(input logic [31:0] s);
        cmd_t c;
        put_le(64'd6, 1); put_le(64'h20, 1); put_le({32'd0, s}, 4);
        n_msgs++;
        if (!dropping) begin
            model_sec = s;
            c = zero_cmd(8'h01);
            exp_q.push_back(c);
        end
    endfunction

    function automatic void add_add(input bit is_short, input logic [63:0] oid, input logic [7:0] side,
                                    input logic [31:0] qty, input logic [47:0] sym,
                                    input logic [63:0] price, input logic [31:0] tofs);
        cmd_t c;
        c = zero_cmd(8'h02);
        put_le(is_short ? 64'd26 : 64'd34, 1); put_le(is_short ? 64'h22 : 64'h21, 1);
        put_le({32'd0, tofs}, 4); put_le(oid, 8); put_le({56'd0, side}, 1);
        put_le({32'd0, qty}, is_short ? 2 : 4);
        for (int k = 5; k >= 0; k--) body_q.push_back(sym[k*8 +: 8]);
        put_le(price, is_short ? 2 : 8);
        put_le(64'($urandom_range(0, 255)), 1);
        n_msgs++;
        c.ns = {32'd0, tofs}; c.oid = oid; c.side = side; c.sym = {sym, 16'h0000};
        c.qty   = is_short ? {16'd0, qty[15:0]} : qty;
        c.price = is_short ? {48'd0, price[15:0]} * 64'd100 : price;
        push_exp(c);
    endfunction

    function automatic void add_exec(input logic [63:0] oid, input logic [31:0] eq, input logic [31:0] tofs);
        cmd_t c;
        c = zero_cmd(8'h03);
        put_le(64'd26, 1); put_le(64'h23, 1); put_le({32'd0, tofs}, 4); put_le(oid, 8);
        put_le({32'd0, eq}, 4); put_le({$urandom, $urandom}, 8);
        n_msgs++;
        c.ns = {32'd0, tofs}; c.oid = oid; c.exe = eq;
        push_exp(c);
    endfunction

    function automatic void add_reduce(input bit is_short, input logic [63:0] oid,
                                       input logic [31:0] cq, input logic [31:0] tofs);
        cmd_t c;
        c = zero_cmd(8'h04);
        put_le(is_short ? 64'd16 : 64'd18, 1); put_le(is_short ? 64'h26 : 64'h25, 1);
        put_le({32'd0, tofs}, 4); put_le(oid, 8); put_le({32'd0, cq}, is_short ? 2 : 4);
        n_msgs++;
        c.ns = {32'd0, tofs}; c.oid = oid; c.cxl = is_short ? {16'd0, cq[15:0]} : cq;
        push_exp(c);
    endfunction

    function automatic void add_delete(input logic [63:0] oid, input logic [31:0] tofs);
        cmd_t c;
        c = zero_cmd(8'h05);
        put_le(64'd14, 1); put_le(64'h29, 1); put_le({32'd0, tofs}, 4); put_le(oid, 8);
        n_msgs++;
        c.ns = {32'd0, tofs}; c.oid = oid;
        push_exp(c);
    endfunction

    function automatic void add_unknown(input int len, input logic [7:0] typ);
        put_le(64'(len), 1); put_le({56'd0, typ}, 1);
        for (int k = 2; k < len; k++) put_le(64'($urandom_range(0, 255)), 1);
        n_msgs++;
    endfunction

    function automatic void add_random_msg();
        logic [63:0] oid;
        logic [31:0] tofs;
        logic [7:0]  t;
        oid  = {$urandom, $urandom};
        tofs = $urandom;
        case ($urandom_range(0, 7))
            0: add_time($urandom);
            1: add_add(1'b0, oid, ($urandom_range(0, 1) == 0) ? 8'h42 : 8'h53, $urandom,
                       {16'h4142, $urandom}, {$urandom, $urandom}, tofs);
            2: add_add(1'b1, oid, ($urandom_range(0, 1) == 0) ? 8'h42 : 8'h53, $urandom,
                       {16'h5859, $urandom}, {$urandom, $urandom}, tofs);
            3: add_exec(oid, $urandom, tofs);
            4: add_reduce(1'b0, oid, $urandom, tofs);
            5: add_reduce(1'b1, oid, $urandom, tofs);
            6: add_delete(oid, tofs);
            default: begin
                t = 8'($urandom_range(0, 255));
                if (t == 8'h20 || t == 8'h21 || t == 8'h22 || t == 8'h23 || t == 8'h25 ||
                    t == 8'h26 || t == 8'h29) t = 8'h99;
                add_unknown($urandom_range(2, 20), t);
            end
        endcase
    endfunction

    function automatic void finish_pkt();
        int len;
        len = 8 + body_q.size();
        pkt_q.delete();
        pkt_q.push_back(len[7:0]); pkt_q.push_back(len[15:8]);
        pkt_q.push_back(8'(n_msgs)); pkt_q.push_back(8'd1);
        for (int k = 0; k < 4; k++) pkt_q.push_back(seq_no[k*8 +: 8]);
        foreach (body_q[i]) pkt_q.push_back(body_q[i]);
        body_q.delete();
        dropping = 1'b0;
        n_msgs = 0;
        seq_no++;
    endfunction

    task automatic send_word(input logic [63:0] w, input logic [7:0] e);
        int t;
        t = 0;
        @(negedge clk);
        while (!udp_rdy && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (!udp_rdy) begin
            check_eq("udp_ready_timeout", {63'd0, udp_rdy}, 64'd1);
        end else begin
            bytes_in = w; be_in = e; data_valid = 1'b1;
            @(posedge clk);
            #1;
            data_valid = 1'b0;
            check_eq("echo_bytes", echo_o, w);
            check_eq("echo_enables", {56'd0, echo_be_o}, {56'd0, e});
        end
    endtask

    task automatic send_pkt();
        int idx;
        logic [7:0]  m, e;
        logic [63:0] w;
        idx = 0;
        while (idx < pkt_q.size()) begin
            m = 8'($urandom_range(0, 255));
            w = {$urandom, $urandom};
            e = 8'h00;
            for (int l = 7; l >= 0; l--) begin
                if (m[l] && idx < pkt_q.size()) begin
                    w[l*8 +: 8] = pkt_q[idx];
                    e[l] = 1'b1;
                    idx++;
                end
            end
            send_word(w, e);
        end
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        @(negedge clk);
        while (!(exp_q.size() == 0 && udp_rdy && !cmd_valid) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 5000) check_eq("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    // Command sink: chooses ready each cycle, scores every transfer against the expected queue.
    initial begin
        cmd_t c;
        cmd_rdy = 1'b0;
        forever begin
            @(negedge clk);
            case (rdy_mode)
                0:       cmd_rdy = 1'b1;
                1:       cmd_rdy = ($urandom_range(0, 2) != 0);
                default: cmd_rdy = 1'b0;
            endcase
            if (cmd_valid && cmd_rdy && enable_in) begin
                n_xfer++;
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_cmd", 64'(exp_q.size()), 64'd1);
                end else begin
                    c = exp_q.pop_front();
                    check_eq("cmd_type", {56'd0, type_o}, {56'd0, c.typ});
                    check_eq("nanoseconds", ns_o, c.ns);
                    check_eq("seconds", sec_o, c.sec);
                    check_eq("remaining_qty", {32'd0, rem_o}, 64'd0);
                    check_eq("canceled_qty", {32'd0, cxl_o}, {32'd0, c.cxl});
                    check_eq("executed_qty", {32'd0, exe_o}, {32'd0, c.exe});
                    check_eq("price", price_o, c.price);
                    check_eq("symbol", sym_o, c.sym);
                    check_eq("quantity", {32'd0, qty_o}, {32'd0, c.qty});
                    check_eq("order_id", oid_o, c.oid);
                    check_eq("side", {56'd0, side_o}, {56'd0, c.side});
                end
            end
        end
    end

    initial begin
        int n0, t;
        reset = 1'b1; enable_in = 1'b1; enable_clr = 1'b0; soft_rst = 1'b0;
        dbg_rdy = 1'b1; data_valid = 1'b0; bytes_in = 64'd0; be_in = 8'd0;
        model_sec = 32'd0; dropping = 1'b0; n_msgs = 0; seq_no = 1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_eq("rst_cmd_valid", {63'd0, cmd_valid}, 64'd0);
        check_eq("rst_udp_ready", {63'd0, udp_rdy}, 64'd1);
        check_eq("rst_echo", echo_o, 64'd0);
        check_eq("rst_enable_out", {63'd0, enable_out}, 64'd0);
        check_eq("rst_dbg_valid", {63'd0, dbg_valid}, 64'd0);
        check_eq("rst_seconds", sec_o, 64'd0);
        check_eq("rst_order_id", oid_o, 64'd0);

        // Directed Time packet from fixed words.
        model_sec = 32'h0006d219;
        exp_q.push_back(zero_cmd(8'h01));
        send_word(64'h0e00010102000000, 8'hFF);
        send_word(64'h062019d206000000, 8'hFC);
        wait_idle();

        // enable_in low: no input accepted, inverted mirror high.
        @(negedge clk);
        enable_in = 1'b0; bytes_in = 64'h1122334455667788; be_in = 8'hFF; data_valid = 1'b1;
        @(posedge clk); #1;
        check_eq("dis_enable_out", {63'd0, enable_out}, 64'd1);
        check_eq("dis_udp_ready", {63'd0, udp_rdy}, 64'd0);
        @(posedge clk); #1;
        check_eq("dis_echo_held", echo_o, 64'h062019d206000000);
        data_valid = 1'b0; enable_in = 1'b1;
        @(posedge clk); #1;
        check_eq("en_enable_out", {63'd0, enable_out}, 64'd0);

        // Time then Add Long AAPL.
        add_time(32'h0006d219); finish_pkt(); send_pkt();
        add_add(1'b0, 64'd5, 8'h42, 32'd100, 48'h4141504C2020, 64'd1500000, 32'd777); finish_pkt(); send_pkt();
        wait_idle();

        // Command sink stalls for 20 cycles on a Delete.
        rdy_mode = 2;
        add_delete(64'hDEAD_BEEF_0000_0042, 32'd1234); finish_pkt(); send_pkt();
        t = 0;
        while (!cmd_valid && t < 500) begin @(negedge clk); t++; end
        check_eq("stall_valid_seen", {63'd0, cmd_valid}, 64'd1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_eq("stall_valid_held", {63'd0, cmd_valid}, 64'd1);
            check_eq("stall_oid_stable", oid_o, 64'hDEAD_BEEF_0000_0042);
            check_eq("stall_udp_ready", {63'd0, udp_rdy}, 64'd0);
        end
        n0 = n_xfer;
        rdy_mode = 0;
        wait_idle();
        check_eq("stall_one_xfer", 64'(n_xfer - n0), 64'd1);

        // Unknown type between two Deletes.
        n0 = n_xfer;
        add_delete(64'd11, 32'd1); add_unknown(10, 8'h99); add_delete(64'd12, 32'd2);
        finish_pkt(); send_pkt();
        wait_idle();
        check_eq("unknown_two_xfers", 64'(n_xfer - n0), 64'd2);

        // Length 1 drops the remainder; next packet decodes.
        n0 = n_xfer;
        add_delete(64'd21, 32'd3);
        put_le(64'd1, 1); dropping = 1'b1;
        add_delete(64'd22, 32'd4);
        finish_pkt(); send_pkt();
        add_delete(64'd23, 32'd5); finish_pkt(); send_pkt();
        wait_idle();
        check_eq("malformed_xfers", 64'(n_xfer - n0), 64'd2);

        // Soft reset mid-message.
        dropping = 1'b1;
        add_delete(64'd31, 32'd6);
        finish_pkt();
        while (pkt_q.size() > 13) void'(pkt_q.pop_back());
        send_pkt();
        t = 0;
        while (!udp_rdy && t < 200) begin @(negedge clk); t++; end
        soft_rst = 1'b1;
        @(posedge clk); #1 soft_rst = 1'b0;
        model_sec = 32'd0;
        check_eq("srst_cmd_valid", {63'd0, cmd_valid}, 64'd0);
        check_eq("srst_seconds", sec_o, 64'd0);
        check_eq("srst_order_id", oid_o, 64'd0);
        check_eq("srst_echo", echo_o, 64'd0);
        check_eq("srst_udp_ready", {63'd0, udp_rdy}, 64'd1);
        add_add(1'b1, 64'd41, 8'h53, 32'd250, 48'h4D5346542020, 64'd1234, 32'd9); finish_pkt(); send_pkt();
        add_time(32'h00012345); finish_pkt(); send_pkt();
        wait_idle();

        // enable_clr behaves like soft reset.
        @(negedge clk);
        enable_clr = 1'b1;
        @(posedge clk); #1 enable_clr = 1'b0;
        model_sec = 32'd0;
        check_eq("clr_echo", echo_o, 64'd0);
        check_eq("clr_type", {56'd0, type_o}, 64'd0);
        add_delete(64'd51, 32'd7); finish_pkt(); send_pkt();
        wait_idle();

        // Randomized packets with random sink backpressure.
        rdy_mode = 1;
        for (int p = 0; p < 30; p++) begin
            int nm, mal, pos;
            nm  = $urandom_range(1, 4);
            mal = $urandom_range(0, 9);
            pos = $urandom_range(0, nm - 1);
            for (int m = 0; m < nm; m++) begin
                if (mal == 0 && m == pos) begin
                    put_le(64'($urandom_range(0, 1)), 1);
                    dropping = 1'b1;
                end
                add_random_msg();
            end
            if (mal == 1) begin
                put_le(64'hF0, 1);
                for (int k = 0; k < 3; k++) put_le(64'($urandom_range(0, 255)), 1);
                dropping = 1'b1;
            end
            finish_pkt();
            send_pkt();
        end
        wait_idle();
        rdy_mode = 0;
        check_eq("leftover_expected", 64'(exp_q.size()), 64'd0);
        check_eq("end_dbg_valid", {63'd0, dbg_valid}, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bats_parser_ip.md
Name: bats_parser_ip

Overview:
- Streaming decoder for BATS/CBOE PITCH binary market-data carried in UDP payloads.
- Accepts 64-bit payload words with byte enables, walks the sequenced unit header and the messages inside it, and emits one decoded order-book command per recognised message over a valid/ready port.
- Sits between the UDP receive path and the order-book engine in the 40 MHz domain.

Parameters:
- MSG_BUF_BYTES, 40: message assembly buffer depth in bytes; must be at least 34, the largest supported message.

Ports:
- Clk40 in 1: sole clock.
- reset in 1: synchronous active-high reset.
- enable_in in 1: run enable; while low, no input accepted and all state held.
- enable_out out 1: registered copy of !enable_in.
- enable_clr in 1: one-cycle pulse; same clear as ctrlind_16_reset.
- ctrlind_00_Ready_For_Debug in 1: debug sink ready.
- ctrlind_01_Debug_Valid out 1: debug word valid.
- ctrlind_02_Debug_Element out 64: debug word.
- ctrlind_03_Ready_for_OrderBook_Command in 1: command sink ready.
- ctrlind_04_OrderBook_Command_Valid out 1: command valid.
- ctrlind_05_Nanoseconds_U64 out 64: TimeOffset, zero-extended.
- ctrlind_06_Seconds_U64 out 64: last Time seconds, zero-extended.
- ctrlind_07_Remaining_Quantity_U32 out 32: remaining quantity; always 0 in this revision.
- ctrlind_08_Canceled_Quantity_U32 out 32: canceled quantity.
- ctrlind_09_Executed_Quantity_U32 out 32: executed quantity.
- ctrlind_10_Price_U64 out 64: price, 4 implied decimals.
- ctrlind_11_Symbol_U64 out 64: 6 ASCII characters, first character in [63:56], [15:0] = 0.
- ctrlind_12_Quantity_U32 out 32: add quantity.
- ctrlind_13_Order_Id_U64 out 64: order id.
- ctrlind_14_Side_U8 out 8: 'B' or 'S'.
- ctrlind_15_OrderBook_Command_Type out 8: command code.
- ctrlind_16_reset in 1: soft reset.
- ctrlind_17_Bytes in 64: payload word; first wire byte in [63:56].
- ctrlind_18_Byte_Enables in 8: bit 7 qualifies [63:56] … bit 0 qualifies [7:0].
- ctrlind_19_data_valid in 1: word valid.
- ctrlind_20_Ready_for_Udp_Input out 1: input ready.
- ctrlind_21_Bytes_echo out 64: registered copy of the accepted word.
- ctrlind_22_Bytes_Valid out 8: registered copy of the accepted enables.

Behaviour:
- Reset, soft reset or enable_clr, all on a clock edge:
  - All outputs to 0, except Ready_for_Udp_Input = 1 when enable_in is high.
  - Parser returns to HDR state; latched seconds cleared.
- Input transfer occurs when data_valid & Ready_for_Udp_Input & enable_in.
  - Echo outputs update the next cycle; they hold their value otherwise.
- The accepted word is unpacked one byte per cycle, lane 7 down to lane 0; disabled lanes are skipped.
- Ready_for_Udp_Input is high only when the unpacker is empty and no command is pending.
- HDR state:
  - Collect 8 bytes: Length u16 LE (total packet bytes including header), Count u8, Unit u8, Sequence u32 LE.
  - Remaining packet bytes = Length - 8. Then go to MSG state, or back to HDR state if the remainder is 0.
- MSG state:
  - Collect message Length (1 byte) and Type (1 byte), then Length-2 body bytes. All multi-byte fields are little-endian.
  - On the last byte, decode the message and emit a command.
  - When the packet remainder reaches 0, return to HDR state.
- Malformed message: Length < 2 or Length > remaining packet bytes.
  - Discard the rest of the packet; no command emitted.
- Decode table (body offsets follow Type):
  - 0x20 Time: Seconds u32 → latch seconds; command type 0x01; Seconds_U64 = value.
  - 0x21 Add Long: TimeOffset u32, OrderId u64, Side u8, Qty u32, Symbol 6 bytes, Price u64, Flags. Command type 0x02.
  - 0x22 Add Short: same as Add Long but Qty u16 and Price u16 (Price output = value × 100). Command type 0x02.
  - 0x23 Executed: TimeOffset, OrderId, ExecQty u32, ExecId u64. Command type 0x03.
  - 0x25 Reduce Long: TimeOffset, OrderId, CancelQty u32. Command type 0x04.
  - 0x26 Reduce Short: as Reduce Long with CancelQty u16. Command type 0x04.
  - 0x29 Delete: TimeOffset, OrderId. Command type 0x05.
  - Other types: skipped by Length; no command.
- Command output fields:
  - Non-Time commands carry the latched Seconds.
  - Any field not defined by the message type is 0.
- Command handshake:
  - Valid asserts 1 cycle after the last message byte; fields stay stable while valid is high.
  - Transfer on valid & ready; valid drops the next cycle unless a new command is ready.
  - The parser stalls while a command is pending.

Optional Feature:
- BATS_DEBUG_EN defined:
  - Every accepted input word is also presented on Debug_Element with Debug_Valid, held until Ready_For_Debug.
  - Input ready additionally requires that no debug word is pending.
- BATS_DEBUG_EN not defined:
  - Debug_Valid = 0 and Debug_Element = 0 constantly; Ready_For_Debug is ignored.

Test Plan:
- Reset, then send 64'h0e00010102000000 (enables 8'hFF), then 64'h062019d206000000 (enables 8'hFC), with ready = 1 → one command: type 0x01, Seconds_U64 = 64'h6d219, all other fields 0.
- Time packet, then an Add Long packet (OrderId 5, Side 'B', Qty 100, Symbol "AAPL  ", Price 1500000) → type 0x02 with those values, Seconds = 64'h6d219.
- Command ready held low for 20 cycles during a Delete message → valid held with stable fields, input ready low; one transfer after ready rises.
- Unknown type 0x99 (Length 10) between two Delete messages → exactly two type 0x05 commands.
- Message Length = 1 mid-packet → rest of packet dropped, no command; the next packet header decodes normally.
- Soft reset pulsed mid-message → outputs 0, latched seconds 0; a following Time packet decodes correctly.
